// File: rtl/dma_pkg.sv
// Shared opcodes, mode encodings and default width for the DMA channel counter.
// Build option DMA_AUTO_REINIT_EN is consumed by dma_channel_counter.
package dma_pkg;

    localparam logic [2:0] CMD_NOP        = 3'b000;
    localparam logic [2:0] CMD_LOAD_ADDR  = 3'b001;
    localparam logic [2:0] CMD_LOAD_WC    = 3'b010;
    localparam logic [2:0] CMD_LOAD_CTRL  = 3'b011;
    localparam logic [2:0] CMD_REINIT     = 3'b100;
    localparam logic [2:0] CMD_COUNT      = 3'b101;
    localparam logic [2:0] CMD_CLEAR_DONE = 3'b110;

    typedef enum logic [1:0] {
        MODE_WC_DOWN  = 2'b00,
        MODE_WC_UP    = 2'b01,
        MODE_ADDR_CMP = 2'b10,
        MODE_FREE     = 2'b11
    } mode_e;

    localparam int DEFAULT_DATA_LENGTH = 8;

endpackage

// File: rtl/dma_channel_counter_transfer_complete_detect.sv
// Lookahead transfer-complete comparator, evaluated on the next counter values
// of whichever channel is counting this cycle.
module transfer_complete_detect
    import dma_pkg::*;
#(
    parameter int DATA_LENGTH = DEFAULT_DATA_LENGTH
) (
    input  logic [DATA_LENGTH-1:0] next_addr,
    input  logic [DATA_LENGTH-1:0] next_wc,
    input  logic [DATA_LENGTH-1:0] wc_reg,
    input  mode_e                  mode,
    input  logic                   cinwc,
    output logic                   hit
);

    logic [DATA_LENGTH-1:0] next_wc_inc;

    always_comb begin
        next_wc_inc = next_wc + DATA_LENGTH'(1);
        hit         = 1'b0;
        case (mode)
            MODE_WC_DOWN:  hit = cinwc ? (next_wc == '0) : (next_wc == DATA_LENGTH'(1));
            MODE_WC_UP:    hit = cinwc ? (next_wc == wc_reg) : (next_wc_inc == wc_reg);
            MODE_ADDR_CMP: hit = (next_addr == wc_reg);
            default:       hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/dma_channel_counter.sv
// Multi-channel DMA address/word-count engine with sticky done and level irq.
// Define DMA_AUTO_REINIT_EN to reinitialise a channel the cycle after it completes.
module dma_channel_counter
    import dma_pkg::*;
#(
    parameter int DATA_LENGTH = DEFAULT_DATA_LENGTH,
    parameter int CHANNELS    = 4,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd,
    input  logic [CH_W-1:0]        ch_sel,
    input  logic [DATA_LENGTH-1:0] data_in,
    input  logic                   cin_addr,
    input  logic                   cinwc,
    output logic [DATA_LENGTH-1:0] addr_out,
    output logic [DATA_LENGTH-1:0] wc_out,
    output logic [CHANNELS-1:0]    done,
    output logic [CHANNELS-1:0]    irq,
    input  logic [CHANNELS-1:0]    irq_ack
);

    logic [DATA_LENGTH-1:0] addr_reg_q [CHANNELS];
    logic [DATA_LENGTH-1:0] addr_reg_d [CHANNELS];
    logic [DATA_LENGTH-1:0] addr_cnt_q [CHANNELS];
    logic [DATA_LENGTH-1:0] addr_cnt_d [CHANNELS];
    logic [DATA_LENGTH-1:0] wc_reg_q   [CHANNELS];
    logic [DATA_LENGTH-1:0] wc_reg_d   [CHANNELS];
    logic [DATA_LENGTH-1:0] wc_cnt_q   [CHANNELS];
    logic [DATA_LENGTH-1:0] wc_cnt_d   [CHANNELS];
    mode_e                  mode_q     [CHANNELS];
    mode_e                  mode_d     [CHANNELS];
    logic [CHANNELS-1:0]    dir_q, dir_d;
    logic [CHANNELS-1:0]    done_q, done_d;
    logic [CHANNELS-1:0]    irq_q, irq_d;
    logic [CHANNELS-1:0]    rise;
    logic                   ready_q, ready_d;
`ifdef DMA_AUTO_REINIT_EN
    logic [CHANNELS-1:0]    reinit_q, reinit_d;
`endif

    logic                   sel_ok;
    logic [CH_W-1:0]        sel_idx;
    logic                   cmd_fire;
    logic [DATA_LENGTH-1:0] next_addr, next_wc;
    logic                   hit;

    assign sel_ok  = int'(ch_sel) < CHANNELS;
    assign sel_idx = sel_ok ? ch_sel : '0;

    assign addr_out  = sel_ok ? addr_cnt_q[sel_idx] : '0;
    assign wc_out    = sel_ok ? wc_cnt_q[sel_idx] : '0;
    assign done      = done_q;
    assign irq       = irq_q;
    assign cmd_ready = ready_q;

    always_comb begin
        next_addr = dir_q[sel_idx] ? addr_cnt_q[sel_idx] - DATA_LENGTH'(cin_addr)
                                   : addr_cnt_q[sel_idx] + DATA_LENGTH'(cin_addr);
        next_wc   = (mode_q[sel_idx] == MODE_WC_DOWN) ? wc_cnt_q[sel_idx] - DATA_LENGTH'(cinwc)
                                                      : wc_cnt_q[sel_idx] + DATA_LENGTH'(cinwc);
    end

    // One comparator serves all channels since only the addressed one can count.
    transfer_complete_detect #(
        .DATA_LENGTH (DATA_LENGTH)
    ) u_detect (
        .next_addr (next_addr),
        .next_wc   (next_wc),
        .wc_reg    (wc_reg_q[sel_idx]),
        .mode      (mode_q[sel_idx]),
        .cinwc     (cinwc),
        .hit       (hit)
    );

    always_comb begin
        addr_reg_d = addr_reg_q;
        addr_cnt_d = addr_cnt_q;
        wc_reg_d   = wc_reg_q;
        wc_cnt_d   = wc_cnt_q;
        mode_d     = mode_q;
        dir_d      = dir_q;
        done_d     = done_q;
        cmd_fire   = cmd_valid && ready_q && sel_ok;

        if (cmd_fire) begin
            case (cmd)
                CMD_LOAD_ADDR: begin
                    addr_reg_d[sel_idx] = data_in;
                    addr_cnt_d[sel_idx] = data_in;
                end
                CMD_LOAD_WC: begin
                    wc_reg_d[sel_idx] = data_in;
                    if (mode_q[sel_idx] == MODE_WC_DOWN)
                        wc_cnt_d[sel_idx] = data_in;
                    else if (mode_q[sel_idx] == MODE_WC_UP)
                        wc_cnt_d[sel_idx] = '0;
                end
                CMD_LOAD_CTRL: begin
                    mode_d[sel_idx] = mode_e'(data_in[1:0]);
                    dir_d[sel_idx]  = data_in[2];
                end
                CMD_REINIT: begin
                    addr_cnt_d[sel_idx] = addr_reg_q[sel_idx];
                    wc_cnt_d[sel_idx]   = (mode_q[sel_idx] == MODE_WC_DOWN) ? wc_reg_q[sel_idx] : '0;
                    done_d[sel_idx]     = 1'b0;
                end
                CMD_COUNT: begin
                    // A finished channel holds its counters unless it free-runs.
                    if (!done_q[sel_idx] || mode_q[sel_idx] == MODE_FREE) begin
                        addr_cnt_d[sel_idx] = next_addr;
                        wc_cnt_d[sel_idx]   = next_wc;
                        done_d[sel_idx]     = hit;
                    end
                end
                CMD_CLEAR_DONE: done_d[sel_idx] = 1'b0;
                default: ;
            endcase
        end

`ifdef DMA_AUTO_REINIT_EN
        for (int i = 0; i < CHANNELS; i++) begin
            if (reinit_q[i]) begin
                addr_cnt_d[i] = addr_reg_q[i];
                wc_cnt_d[i]   = (mode_q[i] == MODE_WC_DOWN) ? wc_reg_q[i] : '0;
                done_d[i]     = 1'b0;
            end
        end
`endif

        rise  = done_d & ~done_q;
        irq_d = rise | (irq_q & ~irq_ack);
`ifdef DMA_AUTO_REINIT_EN
        reinit_d = rise;
        ready_d  = ~|rise;
`else
        ready_d  = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                addr_reg_q[i] <= '0;
                addr_cnt_q[i] <= '0;
                wc_reg_q[i]   <= '0;
                wc_cnt_q[i]   <= '0;
                mode_q[i]     <= MODE_WC_DOWN;
            end
            dir_q    <= '0;
            done_q   <= '0;
            irq_q    <= '0;
            ready_q  <= 1'b0;
`ifdef DMA_AUTO_REINIT_EN
            reinit_q <= '0;
`endif
        end else begin
            addr_reg_q <= addr_reg_d;
            addr_cnt_q <= addr_cnt_d;
            wc_reg_q   <= wc_reg_d;
            wc_cnt_q   <= wc_cnt_d;
            mode_q     <= mode_d;
            dir_q      <= dir_d;
            done_q     <= done_d;
            irq_q      <= irq_d;
            ready_q    <= ready_d;
`ifdef DMA_AUTO_REINIT_EN
            reinit_q   <= reinit_d;
`endif
        end
    end

endmodule

// File: tb/tb_dma_channel_counter.sv
// Randomised and directed bench for dma_channel_counter against an arithmetic model.
module tb_dma_channel_counter;

    localparam int DL = 8;
    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [2:0]     cmd = 3'b000;
    logic [1:0]     ch_sel = 2'd0;
    logic [DL-1:0]  data_in = '0;
    logic           cin_addr = 1'b0;
    logic           cinwc = 1'b0;
    logic [DL-1:0]  addr_out;
    logic [DL-1:0]  wc_out;
    logic [NCH-1:0] done;
    logic [NCH-1:0] irq;
    logic [NCH-1:0] irq_ack = '0;

    int total = 0;
    int bad = 0;

    int m_addr_reg [NCH];
    int m_addr_cnt [NCH];
    int m_wc_reg   [NCH];
    int m_wc_cnt   [NCH];
    int m_mode     [NCH];
    int m_dir      [NCH];
    bit [NCH-1:0] m_done, m_irq, m_reinit;
    bit m_ready;

    always #5 clk = ~clk;

    dma_channel_counter #(
        .DATA_LENGTH (DL),
        .CHANNELS    (NCH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .ch_sel    (ch_sel),
        .data_in   (data_in),
        .cin_addr  (cin_addr),
        .cinwc     (cinwc),
        .addr_out  (addr_out),
        .wc_out    (wc_out),
        .done      (done),
        .irq       (irq),
        .irq_ack   (irq_ack)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < NCH; i++) begin
            m_addr_reg[i] = 0; m_addr_cnt[i] = 0; m_wc_reg[i] = 0;
            m_wc_cnt[i] = 0;   m_mode[i] = 0;     m_dir[i] = 0;
        end
        m_done = '0; m_irq = '0; m_reinit = '0; m_ready = 1'b0;
    endtask

    task automatic modelReinit(input int ch);
        m_addr_cnt[ch] = m_addr_reg[ch];
        m_wc_cnt[ch]   = (m_mode[ch] == 0) ? m_wc_reg[ch] : 0;
        m_done[ch]     = 1'b0;
    endtask

    // Applies the rules of one clock edge to the model.
    task automatic modelEdge(input bit valid, input logic [2:0] c, input int ch, input int d,
                             input bit ca, input bit cwc, input logic [NCH-1:0] ack);
        bit [NCH-1:0] prev_done = m_done;
        bit [NCH-1:0] rises;
        int na, nw;
        bit la;
        if (valid && m_ready) begin
            case (c)
                3'b001: begin m_addr_reg[ch] = d; m_addr_cnt[ch] = d; end
                3'b010: begin
                    m_wc_reg[ch] = d;
                    if (m_mode[ch] == 0) m_wc_cnt[ch] = d;
                    else if (m_mode[ch] == 1) m_wc_cnt[ch] = 0;
                end
                3'b011: begin m_mode[ch] = d % 4; m_dir[ch] = (d / 4) % 2; end
                3'b100: modelReinit(ch);
                3'b101: begin
                    if (!(m_done[ch] && m_mode[ch] != 3)) begin
                        na = (m_dir[ch] ? m_addr_cnt[ch] - ca : m_addr_cnt[ch] + ca) & 255;
                        nw = (m_mode[ch] == 0 ? m_wc_cnt[ch] - cwc : m_wc_cnt[ch] + cwc) & 255;
                        case (m_mode[ch])
                            0: la = (nw == (cwc ? 0 : 1));
                            1: la = (((nw + (cwc ? 0 : 1)) & 255) == m_wc_reg[ch]);
                            2: la = (na == m_wc_reg[ch]);
                            default: la = 1'b0;
                        endcase
                        m_addr_cnt[ch] = na;
                        m_wc_cnt[ch]   = nw;
                        m_done[ch]     = la;
                    end
                end
                3'b110: m_done[ch] = 1'b0;
                default: ;
            endcase
        end
`ifdef DMA_AUTO_REINIT_EN
        for (int i = 0; i < NCH; i++)
            if (m_reinit[i]) modelReinit(i);
`endif
        rises = m_done & ~prev_done;
        m_irq = rises | (m_irq & ~ack);
`ifdef DMA_AUTO_REINIT_EN
        m_reinit = rises;
        m_ready  = (rises == '0);
`else
        m_ready  = 1'b1;
`endif
    endtask

    task automatic applyStimulus(input bit valid, input logic [2:0] c, input int ch, input int d,
                                 input bit ca, input bit cwc, input logic [NCH-1:0] ack);
        @(negedge clk);
        cmd_valid = valid; cmd = c; ch_sel = ch[1:0]; data_in = d[DL-1:0];
        cin_addr = ca; cinwc = cwc; irq_ack = ack;
        #1;
        checkOutput("addr_out", {24'd0, addr_out}, m_addr_cnt[ch]);
        checkOutput("wc_out", {24'd0, wc_out}, m_wc_cnt[ch]);
        checkOutput("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_ready});
        @(posedge clk);
        modelEdge(valid, c, ch, d, ca, cwc, ack);
        #1;
        checkOutput("done", {28'd0, done}, {28'd0, m_done});
        checkOutput("irq", {28'd0, irq}, {28'd0, m_irq});
    endtask

    task automatic issue(input logic [2:0] c, input int ch, input int d);
        applyStimulus(1'b1, c, ch, d, 1'b0, 1'b0, '0);
    endtask

    task automatic doReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        cmd_valid = 1'b0; irq_ack = '0;
        #1;
        checkOutput("rst_done", {28'd0, done}, 32'd0);
        checkOutput("rst_irq", {28'd0, irq}, 32'd0);
        checkOutput("rst_ready", {31'd0, cmd_ready}, 32'd0);
        checkOutput("rst_addr", {24'd0, addr_out}, 32'd0);
        checkOutput("rst_wc", {24'd0, wc_out}, 32'd0);
        modelClear();
        @(negedge clk);
        rst_n = 1'b1;
        cmd_valid = 1'b1; cmd = 3'b011; data_in = 8'h03;
        #1;
        checkOutput("release_ready", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk);
        m_ready = 1'b1;
    endtask

    initial begin
        int c, ch, d;
        modelClear();
        doReset();

        // ch0 word count down from 3
        issue(3'b011, 0, 0);
        issue(3'b010, 0, 3);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'b101, 0, 0, 1'b0, 1'b1, '0);
        checkOutput("ch0_done", {31'd0, done[0]}, 32'd1);
        checkOutput("ch0_irq", {31'd0, irq[0]}, 32'd1);
        applyStimulus(1'b1, 3'b101, 0, 0, 1'b0, 1'b1, '0);
        applyStimulus(1'b1, 3'b000, 0, 0, 1'b0, 1'b0, 4'b0001);

        // ch1 word count up to 4, then re-complete while acknowledging
        issue(3'b011, 1, 1);
        issue(3'b010, 1, 4);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3'b101, 1, 0, 1'b0, 1'b1, '0);
        checkOutput("ch1_done", {31'd0, done[1]}, 32'd1);
        issue(3'b110, 1, 0);
        issue(3'b100, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'b101, 1, 0, 1'b0, 1'b1, '0);
        applyStimulus(1'b1, 3'b101, 1, 0, 1'b0, 1'b1, 4'b0010);
        checkOutput("ch1_irq_set_wins", {31'd0, irq[1]}, 32'd1);

        // ch2 address compare, counting down through wrap
        issue(3'b011, 2, 6);
        issue(3'b001, 2, 8'h02);
        issue(3'b010, 2, 8'hFF);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'b101, 2, 0, 1'b1, 1'b0, '0);
        checkOutput("ch2_addr_wrap", {24'd0, addr_out}, 32'hFF);
        checkOutput("ch2_done", {31'd0, done[2]}, 32'd1);

        // ch3 free-running from 0xFE
        issue(3'b011, 3, 0);
        issue(3'b010, 3, 8'hFE);
        issue(3'b011, 3, 3);
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 3'b101, 3, 0, 1'b1, 1'b1, '0);
        checkOutput("ch3_done", {31'd0, done[3]}, 32'd0);
        checkOutput("ch3_wrap", {24'd0, wc_out}, 32'd42);

        doReset();

        for (int n = 0; n < 600; n++) begin
            if (n == 300) doReset();
            c  = ($urandom % 2) ? 5 : $urandom_range(0, 7);
            ch = $urandom_range(0, NCH - 1);
            d  = ($urandom % 2) ? $urandom_range(0, 5) : $urandom_range(0, 255);
            applyStimulus(($urandom % 5) != 0, c[2:0], ch, d, $urandom % 2, $urandom % 2,
                          (($urandom % 4) == 0) ? 4'($urandom) : 4'b0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
